// File: rtl/typed_stream_deser.sv
// Rebuilds one value of type T from a stream of BEAT_W-bit beats, least-significant beat first.
// The finished word is held on out_* until the consumer accepts it.
module typed_stream_deser #(
  parameter type T      = logic [7:0],
  parameter int  BEAT_W = 4,
  localparam int TW      = $bits(T),
  localparam int NBEATS  = (TW + BEAT_W - 1) / BEAT_W,
  localparam int CNT_RAW = $clog2(NBEATS + 1),
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output T                  out_data,
  output logic [CNT_W-1:0]  out_beats,
  output logic              out_err
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [TW-1:0]    acc_reg, acc_next, merged;
  logic             out_valid_reg, out_valid_next;
  T                 out_data_reg, out_data_next;
  logic [CNT_W-1:0] out_beats_reg, out_beats_next;
  logic             out_err_reg, out_err_next;
  logic             beat_fire, word_fire, closing;

  assign in_ready  = (state_reg == COLLECT) || out_ready;
  assign beat_fire = in_valid && in_ready;
  assign word_fire = out_valid_reg && out_ready;
  assign cnt_inc   = cnt_reg + CNT_W'(1);
  assign closing   = in_last || (cnt_inc == CNT_W'(NBEATS));

  // Each slot takes the incoming beat when it is the current position; slots
  // beyond the current position read as zero so a short word carries no residue.
  // The last slot is narrowed so beat bits above TW are dropped.
  generate
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_slot
      localparam int LO = gi * BEAT_W;
      localparam int SW = ((TW - LO) < BEAT_W) ? (TW - LO) : BEAT_W;
      assign merged[LO +: SW] = (cnt_reg == CNT_W'(gi)) ? in_data[SW-1:0] :
                                (CNT_W'(gi) > cnt_reg)  ? '0 :
                                                          acc_reg[LO +: SW];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_beats_next = out_beats_reg;
    out_err_next   = out_err_reg;
    if (word_fire) begin
      out_valid_next = 1'b0;
      state_next     = COLLECT;
    end
    // A beat accepted alongside a word accept starts the next word (cnt_reg is 0 here).
    if (beat_fire) begin
      if (closing) begin
        out_valid_next = 1'b1;
        state_next     = HOLD;
        out_data_next  = T'(merged);
        out_beats_next = cnt_inc;
        out_err_next   = !in_last;
        cnt_next       = '0;
        acc_next       = '0;
      end else begin
        cnt_next = cnt_inc;
        acc_next = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= T'({TW{1'b0}});
      out_beats_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_beats_reg <= out_beats_next;
      out_err_reg   <= out_err_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_beats = out_beats_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_typed_stream_deser.sv
// Bench for typed_stream_deser: directed cases on four parameterisations plus a
// randomized run on the 10-bit/4-bit instance against a queue-based word model.
module tb_typed_stream_deser;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_chk  = 0;
  int n_fail = 0;

  // a: default 8-bit, 4-bit beats
  logic       a_iv, a_ir, a_il, a_ov, a_or, a_oe;
  logic [3:0] a_id;
  logic [7:0] a_od;
  logic [1:0] a_ob;
  // b: 12-bit, 4-bit beats
  logic        b_iv, b_ir, b_il, b_ov, b_or, b_oe;
  logic [3:0]  b_id;
  logic [11:0] b_od;
  logic [1:0]  b_ob;
  // c: 10-bit, 4-bit beats (non-multiple width)
  logic       c_iv, c_ir, c_il, c_ov, c_or, c_oe;
  logic [3:0] c_id;
  logic [9:0] c_od;
  logic [1:0] c_ob;
  // d: 1-bit, 1-bit beats
  logic       d_iv, d_ir, d_il, d_ov, d_or, d_oe;
  logic [0:0] d_id;
  logic       d_od;
  logic [0:0] d_ob;

  typed_stream_deser u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_last(a_il),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_beats(a_ob), .out_err(a_oe));

  typed_stream_deser #(.T(logic [11:0]), .BEAT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_last(b_il),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_beats(b_ob), .out_err(b_oe));

  typed_stream_deser #(.T(logic [9:0]), .BEAT_W(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_last(c_il),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_beats(c_ob), .out_err(c_oe));

  typed_stream_deser #(.T(logic), .BEAT_W(1)) u_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id), .in_last(d_il),
    .out_valid(d_ov), .out_ready(d_or), .out_data(d_od), .out_beats(d_ob), .out_err(d_oe));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word value = sum of beats, beat i weighted by 16**i, truncated to tw bits.
  function automatic logic [31:0] pack_beats(input logic [3:0] q[$], input int tw);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < q.size(); i++) acc = acc + (32'(q[i]) << (4 * i));
    return acc & ((32'd1 << tw) - 32'd1);
  endfunction

  logic [3:0]  pin_q[$];
  logic [3:0]  mq[$];
  bit          m_valid;
  logic [31:0] m_data;
  int          m_beats;
  bit          m_err;
  bit          exp_ready;
  int          words_seen;

  initial begin
    rst = 1'b1;
    {a_iv, a_il, a_or, a_id} = '0;
    {b_iv, b_il, b_or, b_id} = '0;
    {c_iv, c_il, c_or, c_id} = '0;
    {d_iv, d_il, d_or, d_id} = '0;

    pin_q = '{4'hF, 4'hF, 4'hF};
    chk("model_pin_3ff", pack_beats(pin_q, 10), 32'h3FF);
    pin_q = '{4'h1, 4'h2, 4'h3};
    chk("model_pin_321", pack_beats(pin_q, 12), 32'h321);

    repeat (2) @(negedge clk);
    chk("rst_a_out_valid", 32'(a_ov), 32'h0);
    chk("rst_a_out_data",  32'(a_od), 32'h0);
    chk("rst_a_out_beats", 32'(a_ob), 32'h0);
    chk("rst_a_out_err",   32'(a_oe), 32'h0);
    chk("rst_a_in_ready",  32'(a_ir), 32'h1);
    chk("rst_b_out_valid", 32'(b_ov), 32'h0);
    chk("rst_d_out_valid", 32'(d_ov), 32'h0);
    rst = 1'b0;

    // 8-bit: 0x5 then 0xA(last) -> 0xA5
    a_or = 1'b1; a_iv = 1'b1; a_id = 4'h5; a_il = 1'b0;
    @(negedge clk); a_id = 4'hA; a_il = 1'b1;
    @(negedge clk); a_iv = 1'b0; a_il = 1'b0;
    chk("t1_out_valid", 32'(a_ov), 32'h1);
    chk("t1_out_data",  32'(a_od), 32'hA5);
    chk("t1_out_beats", 32'(a_ob), 32'h2);
    chk("t1_out_err",   32'(a_oe), 32'h0);
    $display("t1 word %h beats %0d err %0d", a_od, a_ob, a_oe);
    @(negedge clk);
    chk("t1_valid_drop", 32'(a_ov), 32'h0);

    // 12-bit: single beat with last, then three beats without last
    b_or = 1'b1; b_iv = 1'b1; b_id = 4'h3; b_il = 1'b1;
    @(negedge clk);
    chk("t2a_out_data",  32'(b_od), 32'h003);
    chk("t2a_out_beats", 32'(b_ob), 32'h1);
    chk("t2a_out_err",   32'(b_oe), 32'h0);
    $display("t2a word %h beats %0d err %0d", b_od, b_ob, b_oe);
    b_id = 4'h1; b_il = 1'b0;
    @(negedge clk); b_id = 4'h2;
    @(negedge clk); b_id = 4'h3;
    @(negedge clk); b_iv = 1'b0;
    chk("t2b_out_valid", 32'(b_ov), 32'h1);
    chk("t2b_out_data",  32'(b_od), 32'h321);
    chk("t2b_out_beats", 32'(b_ob), 32'h3);
    chk("t2b_out_err",   32'(b_oe), 32'h1);
    $display("t2b word %h beats %0d err %0d", b_od, b_ob, b_oe);
    @(negedge clk);

    // 10-bit: F,F,F(last) -> 0x3FF
    c_or = 1'b1; c_iv = 1'b1; c_id = 4'hF; c_il = 1'b0;
    @(negedge clk);
    @(negedge clk); c_il = 1'b1;
    @(negedge clk); c_iv = 1'b0; c_il = 1'b0;
    chk("t3_out_data",  32'(c_od), 32'h3FF);
    chk("t3_out_beats", 32'(c_ob), 32'h3);
    chk("t3_out_err",   32'(c_oe), 32'h0);
    $display("t3 word %h beats %0d err %0d", c_od, c_ob, c_oe);
    @(negedge clk);

    // Backpressure: 0x5A held for 5 cycles while a 0x7 beat is offered
    a_or = 1'b0; a_iv = 1'b1; a_id = 4'hA; a_il = 1'b0;
    @(negedge clk); a_id = 4'h5; a_il = 1'b1;
    @(negedge clk); a_id = 4'h7; a_il = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(a_ov), 32'h1);
      chk("t4_hold_ready", 32'(a_ir), 32'h0);
      chk("t4_hold_data",  32'(a_od), 32'h5A);
      @(negedge clk);
    end
    a_or = 1'b1;
    #1 chk("t4_ready_comb", 32'(a_ir), 32'h1);
    @(negedge clk);
    chk("t4_accept_valid", 32'(a_ov), 32'h0);
    a_id = 4'h8; a_il = 1'b1;
    @(negedge clk); a_iv = 1'b0; a_il = 1'b0;
    chk("t4_next_data",  32'(a_od), 32'h87);
    chk("t4_next_beats", 32'(a_ob), 32'h2);
    $display("t4 word %h beats %0d err %0d", a_od, a_ob, a_oe);
    @(negedge clk);

    // 1-bit: back-to-back words 1,0,1
    d_or = 1'b1; d_iv = 1'b1; d_il = 1'b0; d_id = 1'b1;
    @(negedge clk);
    chk("t5_w0_valid", 32'(d_ov), 32'h1);
    chk("t5_w0_data",  32'(d_od), 32'h1);
    chk("t5_w0_err",   32'(d_oe), 32'h1);
    chk("t5_w0_beats", 32'(d_ob), 32'h1);
    d_id = 1'b0;
    @(negedge clk);
    chk("t5_w1_valid", 32'(d_ov), 32'h1);
    chk("t5_w1_data",  32'(d_od), 32'h0);
    chk("t5_w1_err",   32'(d_oe), 32'h1);
    d_id = 1'b1;
    @(negedge clk);
    chk("t5_w2_valid", 32'(d_ov), 32'h1);
    chk("t5_w2_data",  32'(d_od), 32'h1);
    d_iv = 1'b0;
    @(negedge clk);
    chk("t5_drain", 32'(d_ov), 32'h0);
    $display("t5 three 1-bit words done");

    // Reset mid-word on the 12-bit instance
    b_or = 1'b1; b_iv = 1'b1; b_id = 4'h9; b_il = 1'b0;
    @(negedge clk); b_id = 4'h6;
    @(negedge clk); b_iv = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_rst_valid", 32'(b_ov), 32'h0);
    chk("t6_rst_data",  32'(b_od), 32'h0);
    b_iv = 1'b1; b_id = 4'hB;
    @(negedge clk); b_id = 4'hC;
    @(negedge clk); b_id = 4'hD; b_il = 1'b1;
    @(negedge clk); b_iv = 1'b0; b_il = 1'b0;
    chk("t6_out_valid", 32'(b_ov), 32'h1);
    chk("t6_out_data",  32'(b_od), 32'hDCB);
    chk("t6_out_beats", 32'(b_ob), 32'h3);
    chk("t6_out_err",   32'(b_oe), 32'h0);
    $display("t6 word %h beats %0d err %0d", b_od, b_ob, b_oe);

    // Randomized run on the 10-bit instance
    rst = 1'b1; c_iv = 1'b0; c_or = 1'b0; c_il = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_valid = 1'b0; mq.delete(); words_seen = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd_out_valid", 32'(c_ov), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_out_data",  32'(c_od), m_data);
        chk("rnd_out_beats", 32'(c_ob), 32'(m_beats));
        chk("rnd_out_err",   32'(c_oe), 32'(m_err));
      end
      rst  = ($urandom_range(0, 249) == 0);
      c_iv = ($urandom_range(0, 9) < 7);
      c_or = ($urandom_range(0, 9) < 6);
      c_il = ($urandom_range(0, 9) < 3);
      c_id = 4'($urandom);
      exp_ready = !m_valid || c_or;
      #1 chk("rnd_in_ready", 32'(c_ir), 32'(exp_ready));
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b0;
        mq.delete();
      end else begin
        if (m_valid && c_or) begin
          words_seen++;
          $display("rnd word %0d data %h beats %0d err %0d", words_seen, m_data, m_beats, m_err);
          m_valid = 1'b0;
        end
        if (c_iv && exp_ready) begin
          mq.push_back(c_id);
          if (c_il || mq.size() == 3) begin
            m_valid = 1'b1;
            m_data  = pack_beats(mq, 10);
            m_beats = mq.size();
            m_err   = !c_il;
            mq.delete();
          end
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/typed_stream_deser.md
Name: typed_stream_deser

Overview:
Deserializer that rebuilds one value of a type parameter `T` from a stream of narrow `BEAT_W`-bit beats, least-significant beat first.
- It is the receive end of the typed-stream path. The sending end slices a `T` into beats.
- Exercises type parameters with and without defaults, including non-multiple widths, and `$bits(T)`-derived arithmetic.
- Sits between a narrow link and any block consuming a whole `T`.

Parameters:
- `T`, default `logic [7:0]`: type of the reassembled value; any packed type, including enum and multi-dimensional packed types.
- `BEAT_W`, default `4`: width of one input beat, in bits; must be ≥ 1.
- `NBEATS` (localparam): `($bits(T) + BEAT_W - 1) / BEAT_W`; number of beats in a full word.
- `CNT_W` (localparam): `$clog2(NBEATS+1)`, minimum 1.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  beat present.
- `in_ready`  output  1  block can accept a beat this cycle.
- `in_data`  input  `BEAT_W`  beat payload.
- `in_last`  input  1  final beat of the current word.
- `out_valid`  output  1  reassembled word available.
- `out_ready`  input  1  consumer accepts the word.
- `out_data`  output  `$bits(T)` (typed `T`)  reassembled value.
- `out_beats`  output  `CNT_W`  number of beats that formed `out_data`.
- `out_err`  output  1  word closed by hitting `NBEATS` without `in_last`.

Behaviour:
- Reset (synchronous, `rst`=1 at an edge):
  - state = COLLECT, beat count = 0, accumulator = 0.
  - `out_valid`=0, `out_data`=0, `out_beats`=0, `out_err`=0.
  - Reset overrides any in-flight beat or pending word; a partial word is discarded with no output.
- States:
  - COLLECT: accumulating beats.
  - HOLD: word presented on `out_*`.
- Handshakes:
  - Beat accepted ⇔ `in_valid && in_ready`.
  - Word accepted ⇔ `out_valid && out_ready`.
  - `in_ready` = (state==COLLECT) || `out_ready`. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
- Beat placement:
  - Beat k (0-based) occupies accumulator bits `[k*BEAT_W +: BEAT_W]`.
  - Bits of the final beat above `$bits(T)` are discarded.
  - Bits not written by any beat of the word are 0.
  - The accumulator clears at word start.
- Word close: on an accepted beat with `in_last`=1 OR count+1 == `NBEATS`:
  - Next cycle: `out_valid`=1 and state=HOLD.
  - `out_data` = accumulator with the beat merged in.
  - `out_beats` = count+1.
  - `out_err` = (`in_last`==0).
  - Count resets to 0.
- Latency: one cycle from the accepted closing beat to `out_valid`=1.
- `in_last`=1 together with count+1 == `NBEATS`: normal close, `out_err`=0.
- HOLD:
  - `out_*` are stable while `out_ready`=0.
  - On word accept with no accepted beat: `out_valid`→0 and state→COLLECT.
  - On word accept in the same cycle as an accepted beat: that beat is beat 0 of the next word.
  - If that beat also closes the word (`in_last`=1 or `NBEATS`==1), `out_valid` stays 1 and the new word is presented next cycle. This gives back-to-back throughput of one word per cycle when `NBEATS`==1.
- `out_*` hold their last values when `out_valid`=0. Benches check them only while `out_valid`=1.
- `in_valid`=0 in COLLECT: no state change.
- Beat arrival has no timeout.
- Enum `T`: `out_data` is cast from raw bits. Values outside the enum encoding are passed through unchecked.

Test Plan:
- `T=logic[7:0]`, `BEAT_W=4`; beats 0x5, 0xA(last), `out_ready`=1 → one cycle after the 0xA beat: `out_data`=0xA5, `out_beats`=2, `out_err`=0.
- `T=logic[11:0]`, `BEAT_W`=4; single beat 0x3 with last → `out_data`=0x003, `out_beats`=1, `out_err`=0. Then beats 0x1, 0x2, 0x3 with no last → `out_data`=0x321, `out_beats`=3, `out_err`=1.
- `T=logic[9:0]`, `BEAT_W`=4 (`NBEATS`=3); beats 0xF, 0xF, 0xF(last) → `out_data`=0x3FF; the upper 2 bits of beat 2 are dropped.
- Backpressure, 8-bit default: word 0x5A presented with `out_ready`=0 for 5 cycles → `in_ready`=0, `out_data` stable at 0x5A. Then assert `out_ready` together with beat 0x7 → 0x5A accepted; 0x7 is stored as beat 0 of the next word.
- `T=logic`, `BEAT_W`=1 (`NBEATS`=1); `in_valid`=1 and `out_ready`=1 continuously, beats 1,0,1 → `out_valid` high for 3 consecutive cycles with `out_data` 1,0,1, `out_err`=1 each.
- Reset mid-word: two beats of a 12-bit word, then `rst`=1 for one cycle → `out_valid`=0. Next word 0xB, 0xC, 0xD(last) → `out_data`=0xDCB; no residue from the discarded beats.
